// File: rtl/serial_cmd_decoder.sv
// serial_cmd_decoder: UART byte framer feeding controller_fsm, with reply serialiser; optional idle abort under DECODER_TIMEOUT_EN.
// Latency: last frame byte -> out_valid next cycle when FSM idle; tx_valid held until tx_ready, rx bytes dropped (overrun) while busy.
module serial_cmd_decoder
`ifdef DECODER_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 10_000_000)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        ctrlr_busy,
  input  logic [31:0] d_rd,
  input  logic        error,
  output logic [3:0]  cmd,
  output logic [31:0] addr,
  output logic [31:0] d_in,
  output logic        out_valid,
  output logic        overrun
);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, ISSUE, WAIT, REPLY} state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [31:0] reply_sh;
  logic [2:0]  reply_left;
  logic        wait_first;
  logic        frame_done;

`ifdef DECODER_TIMEOUT_EN
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] idle_cnt;
`endif

  function automatic logic op_valid(input logic [7:0] b);
    return (b >= 8'h01) && (b <= 8'h0A);
  endfunction

  function automatic logic has_addr(input logic [3:0] c);
    return c >= 4'd5;
  endfunction

  function automatic logic has_data(input logic [3:0] c);
    return (c == 4'd6) || (c == 4'd8) || (c == 4'd10);
  endfunction

  function automatic logic is_read(input logic [3:0] c);
    return (c == 4'd4) || (c == 4'd5) || (c == 4'd7) || (c == 4'd9);
  endfunction

  // The byte that completes a frame may issue straight away, skipping a cycle parked in ISSUE.
  always_comb begin
    frame_done = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE:    frame_done = op_valid(rx_data) && !has_addr(rx_data[3:0]);
        ADDR:    frame_done = (byte_cnt == 2'd3) && !has_data(cmd);
        DATA:    frame_done = (byte_cnt == 2'd3);
        default: frame_done = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cmd        <= '0;
      addr       <= '0;
      d_in       <= '0;
      out_valid  <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      overrun    <= 1'b0;
      byte_cnt   <= '0;
      reply_sh   <= '0;
      reply_left <= '0;
      wait_first <= 1'b0;
`ifdef DECODER_TIMEOUT_EN
      idle_cnt   <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      overrun   <= rx_valid && (state == ISSUE || state == WAIT || state == REPLY);
      case (state)
        IDLE: if (rx_valid) begin
          if (op_valid(rx_data)) begin
            cmd      <= rx_data[3:0];
            addr     <= '0;
            d_in     <= '0;
            byte_cnt <= '0;
            state    <= has_addr(rx_data[3:0]) ? ADDR : ISSUE;
          end else begin
            state      <= REPLY;
            tx_data    <= NAK;
            tx_valid   <= 1'b1;
            reply_left <= '0;
          end
        end
        ADDR: if (rx_valid) begin
          addr     <= {addr[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state <= has_data(cmd) ? DATA : ISSUE;
        end
        DATA: if (rx_valid) begin
          d_in     <= {d_in[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state <= ISSUE;
        end
        ISSUE: begin
        end
        WAIT: begin
          // busy may not have risen yet on the cycle the strobe is visible
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!ctrlr_busy) begin
            state      <= REPLY;
            tx_valid   <= 1'b1;
            tx_data    <= error ? NAK : ACK;
            reply_sh   <= d_rd;
            reply_left <= (!error && is_read(cmd)) ? 3'd4 : 3'd0;
          end
        end
        REPLY: if (tx_valid && tx_ready) begin
          if (reply_left == 3'd0) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end else begin
            tx_data    <= reply_sh[31:24];
            reply_sh   <= {reply_sh[23:0], 8'h00};
            reply_left <= reply_left - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (state == ISSUE || frame_done) begin
        if (!ctrlr_busy) begin
          out_valid  <= 1'b1;
          wait_first <= 1'b1;
          state      <= WAIT;
        end else begin
          state <= ISSUE;
        end
      end

`ifdef DECODER_TIMEOUT_EN
      if ((state == ADDR || state == DATA) && !rx_valid) begin
        if (idle_cnt == TO_LAST) begin
          idle_cnt   <= '0;
          state      <= REPLY;
          tx_data    <= NAK;
          tx_valid   <= 1'b1;
          reply_left <= '0;
        end else begin
          idle_cnt <= idle_cnt + 24'd1;
        end
      end else begin
        idle_cnt <= '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_serial_cmd_decoder.sv
// Bench for serial_cmd_decoder: frame-level model (expected strobes and reply bytes) checked every cycle.
module tb_serial_cmd_decoder;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ctrlr_busy;
  logic [31:0] d_rd;
  logic        error;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic        out_valid;
  logic        overrun;

  logic emu_busy = 1'b0;
  logic pre_busy = 1'b0;
  assign ctrlr_busy = emu_busy | pre_busy;

  always #5 clk = ~clk;

`ifdef DECODER_TIMEOUT_EN
  serial_cmd_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ctrlr_busy(ctrlr_busy), .d_rd(d_rd), .error(error),
    .cmd(cmd), .addr(addr), .d_in(d_in), .out_valid(out_valid), .overrun(overrun));
`else
  serial_cmd_decoder dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ctrlr_busy(ctrlr_busy), .d_rd(d_rd), .error(error),
    .cmd(cmd), .addr(addr), .d_in(d_in), .out_valid(out_valid), .overrun(overrun));
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] d;
    bit          has_a;
    bit          has_d;
  } exp_cmd_t;

  exp_cmd_t    exp_q[$];
  logic [7:0]  exp_tx[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_ovr = 0;
  int          seen_ovr = 0;
  int          ov_total = 0;
  int          ov_cyc = 0;
  int          last_rx_cyc = 0;
  int          ready_mode = 0;
  logic [63:0] tx_hist = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Controller emulator: accepts the strobe, stays busy three cycles.
  initial forever begin
    tick();
    if (out_valid && !reset) begin
      tick();
      emu_busy = 1'b1;
      repeat (3) tick();
      emu_busy = 1'b0;
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      tick();
      tx_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ((cyc % 2) == 0) : 1'b0;
    end
  end

  // Compare process: every cycle, DUT outputs against the model queues.
  initial begin
    exp_cmd_t   e;
    logic       prev_ov, prev_or, prev_txv, prev_rdy;
    logic [7:0] prev_txd;
    prev_ov = 0; prev_or = 0; prev_txv = 0; prev_rdy = 1; prev_txd = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ov = 0; prev_or = 0; prev_txv = 0; prev_rdy = 1;
      end else begin
        if (out_valid) begin
          ov_total++;
          ov_cyc = cyc;
          check("out_valid_width", prev_ov, 0);
          if (exp_q.size() == 0) check("unexpected_out_valid", out_valid, 0);
          else begin
            e = exp_q.pop_front();
            check("cmd", cmd, e.c);
            if (e.has_a) check("addr", addr, e.a);
            if (e.has_d) check("d_in", d_in, e.d);
          end
        end
        if (prev_txv && !prev_rdy) check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_txd});
        if (tx_valid && tx_ready) begin
          tx_hist = {tx_hist[55:0], tx_data};
          if (exp_tx.size() == 0) check("unexpected_tx", tx_valid, 0);
          else check("tx_byte", tx_data, exp_tx.pop_front());
        end
        if (overrun) begin
          seen_ovr++;
          check("overrun_width", prev_or, 0);
        end
        prev_ov = out_valid; prev_or = overrun; prev_txv = tx_valid;
        prev_rdy = tx_ready; prev_txd = tx_data;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_data = b;
    rx_valid = 1'b1;
    last_rx_cyc = cyc;
    tick();
    rx_valid = 1'b0;
  endtask

  // Model: what the frame must produce, derived from opcode, operands, d_rd and error.
  task automatic frame(input bq_t b, input logic [31:0] rd, input bit err, input bit inj, input int gap);
    exp_cmd_t   e;
    logic [7:0] op;
    bit         valid;
    op = b[0];
    valid = (op >= 8'd1) && (op <= 8'd10);
    e.c = op[3:0];
    e.has_a = valid && (op >= 8'd5);
    e.has_d = valid && (op == 8'd6 || op == 8'd8 || op == 8'd10);
    e.a = 0;
    e.d = 0;
    if (e.has_a) for (int i = 1; i <= 4; i++) e.a = e.a * 256 + 32'(b[i]);
    if (e.has_d) for (int i = 5; i <= 8; i++) e.d = e.d * 256 + 32'(b[i]);
    d_rd = rd;
    error = err;
    if (valid) exp_q.push_back(e);
    if (!valid || err) exp_tx.push_back(8'h15);
    else begin
      exp_tx.push_back(8'h06);
      if (op == 8'd4 || op == 8'd5 || op == 8'd7 || op == 8'd9)
        for (int k = 3; k >= 0; k--) exp_tx.push_back(8'(rd >> (8 * k)));
    end
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i]);
      if (i == 1) repeat (gap) tick();
    end
    if (inj) begin
      tick();
      rx_data = 8'hAA;
      rx_valid = 1'b1;
      exp_ovr++;
      tick();
      rx_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_q.size() != 0 || tx_valid || ctrlr_busy) && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d cycles required=<500", nm, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bq_t b;
    int  t0, n;
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; d_rd = '0; error = 1'b0;
    repeat (3) tick();
    check("rst_cmd", cmd, 0);
    check("rst_addr", addr, 0);
    check("rst_d_in", d_in, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick();

    b = {8'h01};
    frame(b, 32'h0, 0, 0, 0);
    wait_done("pause");
    check("pause_latency", ov_cyc - last_rx_cyc, 1);
    check("pause_tx", tx_hist[7:0], 8'h06);

    ready_mode = 1;
    b = {8'h07, 8'h00, 8'h00, 8'h10, 8'h04};
    frame(b, 32'hDEADBEEF, 0, 0, 0);
    wait_done("mem_rd");
    ready_mode = 0;
    check("mem_rd_cmd", cmd, 4'd7);
    check("mem_rd_addr", addr, 32'h00001004);
    check("mem_rd_tx", tx_hist[39:0], 40'h06DEADBEEF);

    b = {8'h08, 8'h00, 8'h00, 8'h00, 8'h20, 8'h12, 8'h34, 8'h56, 8'h78};
    frame(b, 32'h0, 0, 0, 0);
    wait_done("mem_wr");
    check("mem_wr_cmd", cmd, 4'd8);
    check("mem_wr_addr", addr, 32'h00000020);
    check("mem_wr_d_in", d_in, 32'h12345678);
    check("mem_wr_tx", tx_hist[7:0], 8'h06);

    t0 = ov_total;
    b = {8'h3F};
    frame(b, 32'h0, 0, 0, 0);
    wait_done("bad_op");
    check("bad_op_no_strobe", ov_total, t0);
    check("bad_op_tx", tx_hist[7:0], 8'h15);
    b = {8'h01};
    frame(b, 32'h0, 0, 0, 0);
    wait_done("pause_after_bad");

    b = {8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    frame(b, 32'hCAFEF00D, 1, 1, 0);
    wait_done("reg_rd_err");
    check("reg_rd_err_tx", tx_hist[15:0], 16'h0615);
    check("overrun_seen", seen_ovr, 1);

    t0 = ov_total;
    pre_busy = 1'b1;
    b = {8'h02};
    frame(b, 32'h0, 0, 0, 0);
    repeat (5) tick();
    check("issue_holds", ov_total, t0);
    pre_busy = 1'b0;
    n = cyc;
    wait_done("issue_release");
    check("issue_latency", ov_cyc - n, 1);

    b = {8'h0A, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAB};
    frame(b, 32'h0, 0, 0, 0);
    wait_done("mem_wr_byte");
    b = {8'h09, 8'h00, 8'h00, 8'h01, 8'h00};
    frame(b, 32'h000000AB, 0, 0, 0);
    wait_done("mem_rd_byte");
    b = {8'h06, 8'h00, 8'h00, 8'h00, 8'h03, 8'hA5, 8'h5A, 8'h0F, 8'hF0};
    frame(b, 32'h0, 0, 0, 0);
    wait_done("reg_wr");
    b = {8'h04};
    frame(b, 32'h01020304, 0, 0, 0);
    wait_done("status");
    check("status_tx", tx_hist[39:0], 40'h0601020304);

`ifndef DECODER_TIMEOUT_EN
    b = {8'h05, 8'h00, 8'h00, 8'h00, 8'h44};
    frame(b, 32'h55667788, 0, 0, 200);
    wait_done("slow_frame");
`endif

    send_byte(8'h08);
    for (int i = 0; i < 5; i++) send_byte(8'h11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_frame_addr", addr, 0);
    check("rst_mid_frame_d_in", d_in, 0);
    b = {8'h01};
    frame(b, 32'h0, 0, 0, 0);
    wait_done("after_mid_frame_reset");

    ready_mode = 2;
    b = {8'h04};
    frame(b, 32'h11223344, 0, 0, 0);
    n = 0;
    while (!tx_valid && n < 100) begin tick(); n++; end
    check("reply_stalled", tx_valid, 1);
    reset = 1'b1;
    tick();
    check("rst_mid_reply_tx_valid", tx_valid, 0);
    exp_tx.delete();
    exp_q.delete();
    reset = 1'b0;
    ready_mode = 0;
    tick();
    b = {8'h02};
    frame(b, 32'h0, 0, 0, 0);
    wait_done("after_mid_reply_reset");

`ifdef DECODER_TIMEOUT_EN
    exp_tx.push_back(8'h15);
    send_byte(8'h05);
    send_byte(8'h00);
    n = 0;
    while (!tx_valid && n < 300) begin tick(); n++; end
    check("timeout_latency", cyc - last_rx_cyc, 101);
    wait_done("timeout");
    b = {8'h03};
    frame(b, 32'h0, 0, 0, 0);
    wait_done("after_timeout");
`endif

    check("overrun_count", seen_ovr, exp_ovr);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
